// File: rtl/spi_baud_gen_if.sv
// Control/status bundle between the SPI master FSM and the SCK baud engine.
interface spi_baud_gen_if;
  logic       enable_in;
  logic       start_in;
  logic       cpol_in;
  logic       cpha_in;
  logic [2:0] sppr_in;
  logic [2:0] spr_in;
  logic       sck_out;
  logic       shift_out;
  logic       sample_out;
  logic [3:0] edge_cnt_out;
  logic       busy_out;
  logic       done_out;

  modport master (
    output enable_in, start_in, cpol_in, cpha_in, sppr_in, spr_in,
    input  sck_out, shift_out, sample_out, edge_cnt_out, busy_out, done_out
  );

  modport slave (
    input  enable_in, start_in, cpol_in, cpha_in, sppr_in, spr_in,
    output sck_out, shift_out, sample_out, edge_cnt_out, busy_out, done_out
  );
endinterface

// File: rtl/spi_baud_gen.sv
// SPI SCK timing engine: divides clk_in by (SPPR+1)<<SPR, emits 16 SCK edges with shift/sample strobes.
// Optional SPI_BAUD_GUARD_EN adds LEAD/TRAIL guard half-periods around the SCK burst.
module spi_baud_gen #(
  parameter int unsigned DIV_W = 11,
  parameter int unsigned EDGES = 16
) (
  input  logic          clk_in,
  input  logic          rst_in,
  spi_baud_gen_if.slave bus
);

`ifdef SPI_BAUD_GUARD_EN
  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_RUN, S_TRAIL, S_DONE} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
`endif

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] hm1_q, hm1_d;
  logic [3:0]       edge_q, edge_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             sck_q, sck_d;
  logic             shift_q, shift_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;
  logic             last_edge;

  function automatic logic [DIV_W-1:0] half_m1(input logic [2:0] sppr, input logic [2:0] spr);
    logic [DIV_W-1:0] h;
    h = DIV_W'(sppr) + DIV_W'(1);
    h = h << spr;
    return h - DIV_W'(1);
  endfunction

  assign tick      = (cnt_q == '0);
  assign last_edge = (edge_q == 4'(EDGES - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hm1_d    = hm1_q;
    edge_d   = edge_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    sck_d    = sck_q;
    shift_d  = 1'b0;
    sample_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        sck_d  = bus.cpol_in;
        cnt_d  = '0;
        edge_d = '0;
        if (bus.start_in && bus.enable_in) begin
          cpol_d  = bus.cpol_in;
          cpha_d  = bus.cpha_in;
          hm1_d   = half_m1(bus.sppr_in, bus.spr_in);
          cnt_d   = half_m1(bus.sppr_in, bus.spr_in);
          // CPHA=0 launches the first MOSI bit before any SCK edge
          shift_d = ~bus.cpha_in;
`ifdef SPI_BAUD_GUARD_EN
          state_d = S_LEAD;
`else
          state_d = S_RUN;
`endif
        end
      end

`ifdef SPI_BAUD_GUARD_EN
      S_LEAD: begin
        if (tick) begin
          cnt_d   = hm1_q;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
`endif

      S_RUN: begin
        if (tick) begin
          cnt_d  = hm1_q;
          sck_d  = ~sck_q;
          edge_d = edge_q + 4'd1;
          // edge_q holds completed edges, so edge number k is odd when edge_q is even
          if (!cpha_q) begin
            sample_d = ~edge_q[0];
            shift_d  = edge_q[0] & ~last_edge;
          end else begin
            shift_d  = ~edge_q[0];
            sample_d = edge_q[0];
          end
          if (last_edge) begin
`ifdef SPI_BAUD_GUARD_EN
            state_d = S_TRAIL;
            cnt_d   = hm1_q;
`else
            state_d = S_DONE;
            cnt_d   = '0;
`endif
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

`ifdef SPI_BAUD_GUARD_EN
      S_TRAIL: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
`endif

      S_DONE: begin
        sck_d   = cpol_q;
        cnt_d   = '0;
        edge_d  = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        edge_d  = '0;
        sck_d   = bus.cpol_in;
      end
    endcase

    // SPE low cancels the transfer from any active state without a done pulse
    if (!bus.enable_in && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      edge_d   = '0;
      sck_d    = bus.cpol_in;
      shift_d  = 1'b0;
      sample_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hm1_q    <= '0;
      edge_q   <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      sck_q    <= 1'b0;
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hm1_q    <= hm1_d;
      edge_q   <= edge_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      sck_q    <= sck_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.sck_out      = sck_q;
  assign bus.shift_out    = shift_q;
  assign bus.sample_out   = sample_q;
  assign bus.edge_cnt_out = edge_q;
  assign bus.busy_out     = busy_q;
  assign bus.done_out     = done_q;

endmodule

// File: tb/tb_spi_baud_gen.sv
// Directed self-checking bench for spi_baud_gen; expectations adapt to SPI_BAUD_GUARD_EN.
module tb_spi_baud_gen;

`ifdef SPI_BAUD_GUARD_EN
  localparam int GUARD = 1;
`else
  localparam int GUARD = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  spi_baud_gen_if bus ();

  spi_baud_gen #(.DIV_W(11), .EDGES(16)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic [2:0] sppr, input logic [2:0] spr,
                            input logic pol, input logic pha);
    bus.sppr_in   = sppr;
    bus.spr_in    = spr;
    bus.cpol_in   = pol;
    bus.cpha_in   = pha;
    bus.enable_in = 1'b1;
    tick();
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
  endtask

  // Walks a whole transfer cycle by cycle starting at n=0 (just after the start edge)
  task automatic watch(input string tag, input int h, input logic pol, input logic pha);
    int off, d, edges, k;
    int e_sck, e_cnt, e_str, e_busy, e_done;
    int n_shift, n_samp, n_done, n_busy, first_edge, maxcnt;
    logic exp_sh, exp_sa;
    logic [2:0] sv_sppr, sv_spr;
    logic sv_cpha;
    off = GUARD * h;
    d   = 16 * h + 2 * off;
    e_sck = 0; e_cnt = 0; e_str = 0; e_busy = 0; e_done = 0;
    n_shift = 0; n_samp = 0; n_done = 0; n_busy = 0; first_edge = -1; maxcnt = 0;
    sv_sppr = bus.sppr_in; sv_spr = bus.spr_in; sv_cpha = bus.cpha_in;
    for (int n = 0; n <= d + 1; n++) begin
      if (n == 1) begin
        bus.sppr_in = ~sv_sppr;
        bus.spr_in  = ~sv_spr;
        bus.cpha_in = ~sv_cpha;
      end
      edges = (n < off) ? 0 : ((n - off) / h);
      if (edges > 16) edges = 16;
      exp_sh = (n == 0) && !pha;
      exp_sa = 1'b0;
      if (n >= off + h && n <= off + 16 * h && ((n - off) % h) == 0) begin
        k = (n - off) / h;
        if (!pha) begin
          exp_sa = (k % 2) == 1;
          exp_sh = ((k % 2) == 0) && (k < 16);
        end else begin
          exp_sh = (k % 2) == 1;
          exp_sa = (k % 2) == 0;
        end
      end
      if (bus.sck_out !== (pol ^ ((edges % 2) == 1))) e_sck++;
      if (bus.edge_cnt_out !== 4'(edges % 16)) e_cnt++;
      if (bus.shift_out !== exp_sh || bus.sample_out !== exp_sa) e_str++;
      if (bus.busy_out !== (n <= d)) e_busy++;
      if (bus.done_out !== (n == d)) e_done++;
      if (bus.shift_out === 1'b1) n_shift++;
      if (bus.sample_out === 1'b1) n_samp++;
      if (bus.done_out === 1'b1) n_done++;
      if (bus.busy_out === 1'b1) n_busy++;
      if (first_edge < 0 && bus.sck_out !== pol) first_edge = n;
      if (int'(bus.edge_cnt_out) > maxcnt) maxcnt = int'(bus.edge_cnt_out);
      if (n <= d) tick();
    end
    bus.sppr_in = sv_sppr;
    bus.spr_in  = sv_spr;
    bus.cpha_in = sv_cpha;
    check({tag, " sck_wave_errs"}, e_sck, 0);
    check({tag, " edge_cnt_errs"}, e_cnt, 0);
    check({tag, " strobe_errs"}, e_str, 0);
    check({tag, " busy_errs"}, e_busy, 0);
    check({tag, " done_errs"}, e_done, 0);
    check({tag, " shifts"}, n_shift, 8);
    check({tag, " samples"}, n_samp, 8);
    check({tag, " done_pulses"}, n_done, 1);
    check({tag, " busy_cycles"}, n_busy, d + 1);
    check({tag, " first_edge"}, first_edge, off + h);
    check({tag, " max_edge_cnt"}, maxcnt, 15);
  endtask

  initial begin
    int n_done, n_busy, d;
    bus.enable_in = 1'b0;
    bus.start_in  = 1'b0;
    bus.cpol_in   = 1'b0;
    bus.cpha_in   = 1'b0;
    bus.sppr_in   = '0;
    bus.spr_in    = '0;
    tick();
    tick();
    check("rst sck", bus.sck_out, 0);
    check("rst busy", bus.busy_out, 0);
    check("rst done", bus.done_out, 0);
    check("rst edge_cnt", bus.edge_cnt_out, 0);
    check("rst strobes", {bus.shift_out, bus.sample_out}, 0);
    rst = 1'b0;
    tick();

    // H=1, mode 0
    start_xfer(3'd0, 3'd0, 1'b0, 1'b0);
    watch("t1_h1_m0", 1, 1'b0, 1'b0);
    tick();

    // H=6, mode 3
    start_xfer(3'd2, 3'd1, 1'b1, 1'b1);
    watch("t2_h6_m3", 6, 1'b1, 1'b1);
    tick();
    check("t2 idle sck high", bus.sck_out, 1);

    // H=1024, mode 1
    start_xfer(3'd7, 3'd7, 1'b0, 1'b1);
    watch("t3_h1024", 1024, 1'b0, 1'b1);
    tick();

    // H=2 guard-sensitive run, mode 2
    start_xfer(3'd1, 3'd0, 1'b1, 1'b0);
    watch("t6_h2", 2, 1'b1, 1'b0);
    tick();

    // Abort after SCK edge 5 (H=2, cpol=1, cpha=0)
    start_xfer(3'd1, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10 + 2 * GUARD; i++) tick();
    check("t4 edge_cnt at 5", bus.edge_cnt_out, 5);
    check("t4 sck after edge5", bus.sck_out, 0);
    check("t4 sample at edge5", bus.sample_out, 1);
    bus.enable_in = 1'b0;
    tick();
    check("t4 abort busy", bus.busy_out, 0);
    check("t4 abort sck", bus.sck_out, 1);
    check("t4 abort edge_cnt", bus.edge_cnt_out, 0);
    check("t4 abort strobes", {bus.shift_out, bus.sample_out}, 0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done_out === 1'b1) n_done++;
      tick();
    end
    check("t4 no done", n_done, 0);

    // start while disabled
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    check("t4 start disabled busy", bus.busy_out, 0);
    tick();
    check("t4 start disabled busy2", bus.busy_out, 0);
    bus.enable_in = 1'b1;
    tick();

    // start pulses during RUN and DONE are ignored (H=1)
    start_xfer(3'd0, 3'd0, 1'b0, 1'b0);
    d = 16 + 2 * GUARD;
    n_done = 0;
    n_busy = 0;
    for (int n = 0; n <= d + 6; n++) begin
      if (bus.done_out === 1'b1) begin
        n_done++;
        check("t5 done position", n, d);
      end
      if (bus.busy_out === 1'b1) n_busy++;
      bus.start_in = (n == 3) || (n == d);
      tick();
    end
    bus.start_in = 1'b0;
    check("t5 done count", n_done, 1);
    check("t5 busy cycles", n_busy, d + 1);

    // reset mid-transfer
    start_xfer(3'd1, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    check("t5 pre-rst busy", bus.busy_out, 1);
    rst = 1'b1;
    #1;
    check("t5 rst sck", bus.sck_out, 0);
    check("t5 rst busy", bus.busy_out, 0);
    check("t5 rst edge_cnt", bus.edge_cnt_out, 0);
    check("t5 rst strobes", {bus.shift_out, bus.sample_out, bus.done_out}, 0);
    tick();
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done_out === 1'b1 || bus.busy_out === 1'b1) n_done++;
    end
    check("t5 post-rst quiet", n_done, 0);
    check("t5 post-rst sck follows cpol", bus.sck_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
